// File: rtl/circuit_2.sv
// SR flip-flop built from a T flip-flop: combinational SR->T excitation for an
// external state, plus an internal T core with a saturating forbidden-input counter.
module circuit_2 #(
    parameter int   CNT_W = 8,
    parameter logic RST_Q = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    output logic             t,
    output logic             q_reg,
    output logic             q_n,
    output logic             t_int,
    output logic             invalid,
    output logic [CNT_W-1:0] invalid_cnt
);

    logic             q_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Toggle only when the request differs from the present state; s=r=1 holds.
    function automatic logic sr_to_t(input logic s_f, input logic r_f, input logic q_f);
        return (s_f & ~r_f & ~q_f) | (r_f & ~s_f & q_f);
    endfunction

    always_comb begin
        t       = sr_to_t(s, r, q);
        t_int   = sr_to_t(s, r, q_reg);
        invalid = s & r;
        q_next  = q_reg ^ t_int;
        cnt_next = cnt_reg;
        if (invalid && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg   <= RST_Q;
            cnt_reg <= '0;
        end else begin
            q_reg   <= q_next;
            cnt_reg <= cnt_next;
        end
    end

    assign q_n         = ~q_reg;
    assign invalid_cnt = cnt_reg;

endmodule

// File: tb/tb_circuit_2.sv
// Directed bench for circuit_2: excitation truth table, SR sequencing on the
// internal core, forbidden-input handling, counter saturation and reset priority.
module tb_circuit_2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst2;
    logic       s;
    logic       r;
    logic       q;
    logic       t, q_reg, q_n, t_int, invalid;
    logic [7:0] invalid_cnt;
    logic       t2, q_reg2, q_n2, t_int2, invalid2;
    logic [1:0] invalid_cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    circuit_2 #(.CNT_W(8), .RST_Q(1'b0)) dut (
        .clk(clk), .rst(rst), .s(s), .r(r), .q(q),
        .t(t), .q_reg(q_reg), .q_n(q_n), .t_int(t_int),
        .invalid(invalid), .invalid_cnt(invalid_cnt)
    );

    circuit_2 #(.CNT_W(2), .RST_Q(1'b0)) dut_sat (
        .clk(clk), .rst(rst2), .s(s), .r(r), .q(q),
        .t(t2), .q_reg(q_reg2), .q_n(q_n2), .t_int(t_int2),
        .invalid(invalid2), .invalid_cnt(invalid_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0] tt_exp;
    logic [2:0] vec;

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        s = 1'b0; r = 1'b0; q = 1'b0;

        // Excitation truth table for s r q = 000..111
        tt_exp = 8'b0001_1000;
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            {s, r, q} = vec;
            #1;
            check($sformatf("t_tt_%0d", i), {31'b0, t}, {31'b0, tt_exp[7-i]});
        end
        q = 1'b0;

        // Reset wins over s=1
        @(negedge clk);
        s = 1'b1; r = 1'b0; rst = 1'b1;
        step();
        check("rst_q_reg", {31'b0, q_reg}, 32'd0);
        check("rst_q_n", {31'b0, q_n}, 32'd1);
        check("rst_cnt", {24'b0, invalid_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        check("rel_t_int", {31'b0, t_int}, 32'd1);
        step();
        check("rel_q_reg", {31'b0, q_reg}, 32'd1);

        // Bring core back to 0, then run the SR sequence
        s = 1'b0; r = 1'b1;
        step();
        check("clr_q_reg", {31'b0, q_reg}, 32'd0);

        s = 1'b1; r = 1'b0; #1;
        check("seq0_t_int", {31'b0, t_int}, 32'd1);
        step();
        check("seq0_q_reg", {31'b0, q_reg}, 32'd1);
        s = 1'b0; r = 1'b0; #1;
        check("seq1_t_int", {31'b0, t_int}, 32'd0);
        step();
        check("seq1_q_reg", {31'b0, q_reg}, 32'd1);
        s = 1'b0; r = 1'b1; #1;
        check("seq2_t_int", {31'b0, t_int}, 32'd1);
        step();
        check("seq2_q_reg", {31'b0, q_reg}, 32'd0);
        check("seq2_q_n", {31'b0, q_n}, 32'd1);
        s = 1'b0; r = 1'b0; #1;
        check("seq3_t_int", {31'b0, t_int}, 32'd0);
        step();
        check("seq3_q_reg", {31'b0, q_reg}, 32'd0);

        // Forbidden input holds state and counts edges
        s = 1'b1; r = 1'b0;
        step();
        check("inv_pre_q_reg", {31'b0, q_reg}, 32'd1);
        s = 1'b1; r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("inv%0d_invalid", i), {31'b0, invalid}, 32'd1);
            check($sformatf("inv%0d_t_int", i), {31'b0, t_int}, 32'd0);
            step();
            check($sformatf("inv%0d_q_reg", i), {31'b0, q_reg}, 32'd1);
        end
        check("inv_cnt", {24'b0, invalid_cnt}, 32'd3);

        // Saturation on the 2-bit counter instance
        check("sat_pre_cnt", {30'b0, invalid_cnt2}, 32'd0);
        rst2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("sat%0d_cnt", i), {30'b0, invalid_cnt2},
                  (i < 3) ? 32'(i + 1) : 32'd3);
        end
        check("wide_cnt", {24'b0, invalid_cnt}, 32'd8);

        // Reset in the middle of operation, with s=r=1 active
        s = 1'b0; r = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        s = 1'b1; r = 1'b0;
        step();
        s = 1'b1; r = 1'b1;
        step();
        step();
        check("mid_pre_cnt", {24'b0, invalid_cnt}, 32'd2);
        check("mid_pre_q_reg", {31'b0, q_reg}, 32'd1);
        rst = 1'b1;
        step();
        check("mid_rst_q_reg", {31'b0, q_reg}, 32'd0);
        check("mid_rst_cnt", {24'b0, invalid_cnt}, 32'd0);
        rst = 1'b0;
        s = 1'b1; r = 1'b0;
        step();
        check("resume_q_reg", {31'b0, q_reg}, 32'd1);
        check("resume_cnt", {24'b0, invalid_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
